music_sheet: RTL and testbench



---
 rtl/music_sheet.sv | 188 ++++++++++++++++++
 tb/tb_music_sheet.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/music_sheet.sv
// music_sheet: per-state note track sequencer with square-wave synthesis.
// Optional bass voice on the right channel when MUSIC_STEREO_EN is defined.
module music_sheet #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int TRACK_LEN   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  state,
    input  logic        vol_up,
    input  logic        vol_down,
    input  logic        mute,
    output logic [15:0] audio_in_left,
    output logic [15:0] audio_in_right,
    output logic [2:0]  volume,
    output logic [4:0]  note_idx
);

    localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

    localparam logic [19:0] HP_C4 = 20'(CLK_HZ / (2 * 262));
    localparam logic [19:0] HP_D4 = 20'(CLK_HZ / (2 * 294));
    localparam logic [19:0] HP_E4 = 20'(CLK_HZ / (2 * 330));
    localparam logic [19:0] HP_F4 = 20'(CLK_HZ / (2 * 349));
    localparam logic [19:0] HP_G4 = 20'(CLK_HZ / (2 * 392));
    localparam logic [19:0] HP_A4 = 20'(CLK_HZ / (2 * 440));
    localparam logic [19:0] HP_B4 = 20'(CLK_HZ / (2 * 494));
    localparam logic [19:0] HP_C5 = 20'(CLK_HZ / (2 * 523));

    // One nibble per note, index 0 in the least significant nibble.
    localparam logic [127:0] TRACK0 = 128'h01358531_03456543_04565455_06786566;
    localparam logic [127:0] TRACK1 = 128'h51535153_08765432_15351535_12345678;
    localparam logic [127:0] TRACK2 = 128'h00000000_11223344_00000000_55667788;
    localparam logic [127:0] TRACK3 = 128'h0;

    logic [1:0]    state_q, state_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [4:0]    idx_q, idx_d;
    logic [19:0]   tone_q, tone_d;
    logic          phase_q, phase_d;
    logic [2:0]    vol_q, vol_d;
    logic [15:0]   left_q, left_d;

    logic [127:0]  track;
    logic [3:0]    note_code;
    logic [19:0]   hp;
    logic [15:0]   amp;
    logic          silent;

`ifdef MUSIC_STEREO_EN
    logic [19:0]   tone2_q, tone2_d;
    logic          phase2_q, phase2_d;
    logic [15:0]   right_q, right_d;
    logic [19:0]   hp2;
`endif

    // Note ROM lookup and half-period selection for the current note.
    always_comb begin
        track = TRACK3;
        hp    = '1;
        case (state_q)
            2'd0:    track = TRACK0;
            2'd1:    track = TRACK1;
            2'd2:    track = TRACK2;
            default: track = TRACK3;
        endcase
        note_code = track[{idx_q, 2'b00} +: 4];
        case (note_code)
            4'd1:    hp = HP_C4;
            4'd2:    hp = HP_D4;
            4'd3:    hp = HP_E4;
            4'd4:    hp = HP_F4;
            4'd5:    hp = HP_G4;
            4'd6:    hp = HP_A4;
            4'd7:    hp = HP_B4;
            4'd8:    hp = HP_C5;
            default: hp = '1;
        endcase
    end

    // Sequencer, tone generator, volume and sample next-state logic.
    always_comb begin
        state_d = state;
        beat_d  = beat_q;
        idx_d   = idx_q;
        tone_d  = tone_q;
        phase_d = phase_q;
        vol_d   = vol_q;
`ifdef MUSIC_STEREO_EN
        hp2      = hp + hp;
        tone2_d  = tone2_q;
        phase2_d = phase2_q;
`endif
        if (state_q != state) begin
            beat_d  = '0;
            idx_d   = '0;
            tone_d  = '0;
            phase_d = 1'b0;
`ifdef MUSIC_STEREO_EN
            tone2_d  = '0;
            phase2_d = 1'b0;
`endif
        end else if (beat_q == BW'(BEAT_CYCLES - 1)) begin
            beat_d  = '0;
            idx_d   = (idx_q == 5'(TRACK_LEN - 1)) ? 5'd0 : idx_q + 5'd1;
            tone_d  = '0;
            phase_d = 1'b0;
`ifdef MUSIC_STEREO_EN
            tone2_d  = '0;
            phase2_d = 1'b0;
`endif
        end else begin
            beat_d = beat_q + 1'b1;
            if (tone_q == hp - 20'd1) begin
                tone_d  = '0;
                phase_d = ~phase_q;
            end else begin
                tone_d = tone_q + 20'd1;
            end
`ifdef MUSIC_STEREO_EN
            if (tone2_q == hp2 - 20'd1) begin
                tone2_d  = '0;
                phase2_d = ~phase2_q;
            end else begin
                tone2_d = tone2_q + 20'd1;
            end
`endif
        end

        if (vol_up && !vol_down && vol_q != 3'd5)
            vol_d = vol_q + 3'd1;
        else if (vol_down && !vol_up && vol_q != 3'd1)
            vol_d = vol_q - 3'd1;

        amp    = {1'b0, vol_q, 12'h000};
        silent = (note_code == 4'd0) || mute;
        left_d = silent ? 16'd0 : (phase_q ? amp : (~amp + 16'd1));
`ifdef MUSIC_STEREO_EN
        right_d = silent ? 16'd0 : (phase2_q ? amp : (~amp + 16'd1));
`endif
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= 2'd0;
            beat_q  <= '0;
            idx_q   <= '0;
            tone_q  <= '0;
            phase_q <= 1'b0;
            vol_q   <= 3'd3;
            left_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            idx_q   <= idx_d;
            tone_q  <= tone_d;
            phase_q <= phase_d;
            vol_q   <= vol_d;
            left_q  <= left_d;
        end
    end

`ifdef MUSIC_STEREO_EN
    // Bass voice registers, one octave below the left voice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tone2_q  <= '0;
            phase2_q <= 1'b0;
            right_q  <= '0;
        end else begin
            tone2_q  <= tone2_d;
            phase2_q <= phase2_d;
            right_q  <= right_d;
        end
    end

    assign audio_in_right = right_q;
`else
    assign audio_in_right = left_q;
`endif

    assign audio_in_left = left_q;
    assign volume        = vol_q;
    assign note_idx      = idx_q;

endmodule

// File: tb/tb_music_sheet.sv
// tb_music_sheet: directed checks of music_sheet with a small clock model.
// A4 half-period is 10 cycles and a beat is 64 cycles here.
module tb_music_sheet;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  state = 2'd0;
    logic        vol_up = 1'b0;
    logic        vol_down = 1'b0;
    logic        mute = 1'b0;
    logic [15:0] audio_in_left;
    logic [15:0] audio_in_right;
    logic [2:0]  volume;
    logic [4:0]  note_idx;

    int checks = 0;
    int failures = 0;
    int up_exp [4] = '{4, 5, 5, 5};
    int dn_exp [6] = '{4, 3, 2, 1, 1, 1};

    music_sheet #(
        .CLK_HZ(8800),
        .BEAT_CYCLES(64),
        .TRACK_LEN(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .state(state),
        .vol_up(vol_up),
        .vol_down(vol_down),
        .mute(mute),
        .audio_in_left(audio_in_left),
        .audio_in_right(audio_in_right),
        .volume(volume),
        .note_idx(note_idx)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected sample after edge k of an A4 stretch (track 0, idx 0/1).
    function automatic logic [15:0] wave(input int k, input int half,
                                         input int v);
        logic [15:0] a;
        a = 16'(v * 4096);
        if (((((k - 1) % 64) / half) % 2) == 1)
            return a;
        return ~a + 16'd1;
    endfunction

    function automatic logic [15:0] exp_r(input int k, input int v);
`ifdef MUSIC_STEREO_EN
        return wave(k, 20, v);
`else
        return wave(k, 10, v);
`endif
    endfunction

    initial begin
        repeat (3) tick;
        chk("rst_left", audio_in_left, 16'h0000);
        chk("rst_right", audio_in_right, 16'h0000);
        chk("rst_vol", 16'(volume), 16'd3);
        chk("rst_idx", 16'(note_idx), 16'd0);

        rst = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick;
            chk("a4_left", audio_in_left, wave(k, 10, 3));
            chk("a4_right", audio_in_right, exp_r(k, 3));
        end

        for (int i = 0; i < 4; i++) begin
            vol_up = 1'b1;
            tick;
            vol_up = 1'b0;
            chk("vol_up", 16'(volume), 16'(up_exp[i]));
        end
        tick;
        chk("amp5_left", audio_in_left, wave(35, 10, 5));
        chk("amp5_right", audio_in_right, exp_r(35, 5));

        for (int i = 0; i < 6; i++) begin
            vol_down = 1'b1;
            tick;
            vol_down = 1'b0;
            chk("vol_down", 16'(volume), 16'(dn_exp[i]));
        end
        tick;
        chk("amp1_left", audio_in_left, 16'hF000);

        vol_up = 1'b1;
        tick;
        tick;
        vol_up = 1'b0;
        chk("vol_back3", 16'(volume), 16'd3);
        vol_up = 1'b1;
        vol_down = 1'b1;
        tick;
        vol_up = 1'b0;
        vol_down = 1'b0;
        chk("vol_both", 16'(volume), 16'd3);
        tick;
        chk("amp3_left", audio_in_left, wave(46, 10, 3));

        mute = 1'b1;
        for (int k = 47; k <= 70; k++) begin
            tick;
            chk("mute_left", audio_in_left, 16'h0000);
            chk("mute_right", audio_in_right, 16'h0000);
        end
        chk("mute_idx", 16'(note_idx), 16'd1);
        mute = 1'b0;
        for (int k = 71; k <= 82; k++) begin
            tick;
            chk("unmute_left", audio_in_left, wave(k, 10, 3));
            chk("unmute_right", audio_in_right, exp_r(k, 3));
        end

        vol_up = 1'b1;
        tick;
        vol_up = 1'b0;
        chk("vol_pre_rst", 16'(volume), 16'd4);
        tick;
        chk("amp4_left", audio_in_left, wave(84, 10, 4));

        rst = 1'b1;
        #1;
        chk("midrst_left", audio_in_left, 16'h0000);
        chk("midrst_right", audio_in_right, 16'h0000);
        chk("midrst_vol", 16'(volume), 16'd3);
        chk("midrst_idx", 16'(note_idx), 16'd0);
        repeat (2) tick;
        rst = 1'b0;

        repeat (63) tick;
        chk("beat_hold", 16'(note_idx), 16'd0);
        tick;
        chk("beat_step", 16'(note_idx), 16'd1);
        for (int n = 2; n <= 32; n++) begin
            repeat (64) tick;
            chk("idx_step", 16'(note_idx), 16'(n % 32));
        end

        repeat (84) tick;
        chk("pre_change_idx", 16'(note_idx), 16'd1);
        state = 2'd1;
        tick;
        chk("change_idx", 16'(note_idx), 16'd0);
        tick;
        chk("trk1_left", audio_in_left, 16'hD000);
        chk("trk1_right", audio_in_right, 16'hD000);
        repeat (62) tick;
        chk("trk1_hold", 16'(note_idx), 16'd0);
        tick;
        chk("trk1_step", 16'(note_idx), 16'd1);

        state = 2'd3;
        repeat (2) tick;
        for (int i = 0; i < 4096; i++) begin
            tick;
            chk("silent_left", audio_in_left, 16'h0000);
            chk("silent_right", audio_in_right, 16'h0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
